// File: rtl/map_collider_pkg.sv
// Shared types and defaults for the map collider: FSM states, coordinate width
// and the stock three-platform level layout.
package map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CLAMP,
    ST_COMMIT
  } state_t;

  localparam int unsigned DEF_W        = 10;
  localparam int unsigned DEF_NUM_PLAT = 3;

  // Entry i occupies bits [i*DEF_W +: DEF_W]; entry 0 is the rightmost field.
  localparam logic [DEF_NUM_PLAT*DEF_W-1:0] DEF_PLAT_LEFT  = {10'd420, 10'd210, 10'd0};
  localparam logic [DEF_NUM_PLAT*DEF_W-1:0] DEF_PLAT_RIGHT = {10'd639, 10'd419, 10'd209};
  localparam logic [DEF_NUM_PLAT*DEF_W-1:0] DEF_PLAT_TOP   = {10'd420, 10'd360, 10'd420};

endpackage

// File: rtl/map_collider_plat_clamp.sv
// Combinational evaluation of one platform against the pre-move sprite edges:
// landing clamp, side-wall clamps and the resting-contact term.
module plat_clamp
  import map_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic signed [W+1:0] i_l,
  input  logic signed [W+1:0] i_r,
  input  logic signed [W+1:0] i_b,
  input  logic signed [W+1:0] i_dx,
  input  logic signed [W+1:0] i_dy,
  input  logic        [W-1:0] i_left,
  input  logic        [W-1:0] i_right,
  input  logic        [W-1:0] i_top,
  output logic signed [W+1:0] o_dx,
  output logic signed [W+1:0] o_dy,
  output logic                o_hit_v,
  output logic                o_touch
);

  localparam int unsigned SW = W + 2;

  logic signed [SW-1:0] w_left;
  logic signed [SW-1:0] w_right;
  logic signed [SW-1:0] w_top;
  logic                 w_overlap;
  logic                 w_below;

  assign w_left  = $signed({2'b00, i_left});
  assign w_right = $signed({2'b00, i_right});
  assign w_top   = $signed({2'b00, i_top});

  always_comb begin
    o_dx      = i_dx;
    o_dy      = i_dy;
    o_hit_v   = 1'b0;
    w_overlap = (i_r > w_left) && (i_l < w_right);
    // Sprite bottom below the platform top: the platform acts as a wall.
    w_below   = i_b > w_top;
    if (w_overlap && !w_below && ((i_b + i_dy) > w_top)) begin
      o_dy    = w_top - i_b;
      o_hit_v = 1'b1;
    end
    if (w_below && (i_r <= w_left) && ((i_r + i_dx) > w_left)) begin
      o_dx = w_left - i_r;
    end
    if (w_below && (i_l >= w_right) && ((i_l + i_dx) < w_right)) begin
      o_dx = w_right - i_l;
    end
    o_touch = w_overlap && (i_b == w_top);
  end

endmodule

// File: rtl/map_collider.sv
// Per-frame sprite motion with gravity, clamped against a platform table
// scanned one entry per clock and against the screen edges.
module map_collider
  import map_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned NUM_PLAT = DEF_NUM_PLAT,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned MAX_FALL = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic signed [W-1:0]   req_dX,
  input  logic signed [W-1:0]   req_dY,
  input  logic [W-1:0]          size_X,
  input  logic [W-1:0]          size_Y,
  input  logic [W-1:0]          spawn_X,
  input  logic [W-1:0]          spawn_Y,
  input  logic [NUM_PLAT*W-1:0] plat_left,
  input  logic [NUM_PLAT*W-1:0] plat_right,
  input  logic [NUM_PLAT*W-1:0] plat_top,
  output logic [W-1:0]          pos_X,
  output logic [W-1:0]          pos_Y,
  output logic                  grounded,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int unsigned SW = W + 2;
  localparam int unsigned IW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

  localparam logic signed [SW-1:0] GRAV_S = SW'(GRAVITY);
  localparam logic signed [SW-1:0] MAXF_S = SW'(MAX_FALL);
  localparam logic signed [SW-1:0] XMAX_S = SW'(SCREEN_W - 1);

  state_t               r_state;
  logic [IW-1:0]        r_idx;
  logic [W-1:0]         r_pos_x;
  logic [W-1:0]         r_pos_y;
  logic signed [SW-1:0] r_vy;
  logic signed [SW-1:0] r_vy_n;
  logic signed [SW-1:0] r_dx;
  logic signed [SW-1:0] r_dy;
  logic                 r_hit_v;
  logic                 r_touch;
  logic                 r_grounded;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overrun;

  logic signed [SW-1:0] w_l;
  logic signed [SW-1:0] w_r;
  logic signed [SW-1:0] w_b;
  logic signed [SW-1:0] w_vy_inc;
  logic signed [SW-1:0] w_vy_n;
  logic signed [SW-1:0] w_lx;
  logic signed [SW-1:0] w_rx;
  logic signed [SW-1:0] w_dx_c;
  logic signed [SW-1:0] w_dx_p;
  logic signed [SW-1:0] w_dy_p;
  logic                 w_hit_p;
  logic                 w_touch_p;
  logic                 w_gnd;
  logic [W-1:0]         w_sel_left;
  logic [W-1:0]         w_sel_right;
  logic [W-1:0]         w_sel_top;

  assign w_l = $signed({2'b00, r_pos_x}) - $signed({2'b00, size_X});
  assign w_r = $signed({2'b00, r_pos_x}) + $signed({2'b00, size_X});
  assign w_b = $signed({2'b00, r_pos_y}) + $signed({2'b00, size_Y});

  assign w_vy_inc = r_vy + GRAV_S;
  assign w_vy_n   = r_grounded ? '0 : ((w_vy_inc > MAXF_S) ? MAXF_S : w_vy_inc);

  assign w_gnd = r_hit_v | (r_touch & ~r_dy[SW-1]);

  always_comb begin
    w_sel_left  = '0;
    w_sel_right = '0;
    w_sel_top   = '0;
    for (int unsigned i = 0; i < NUM_PLAT; i++) begin
      if (r_idx == IW'(i)) begin
        w_sel_left  = plat_left[i*W +: W];
        w_sel_right = plat_right[i*W +: W];
        w_sel_top   = plat_top[i*W +: W];
      end
    end
  end

  // Left edge is clamped first; the right-edge test then sees the adjusted dX.
  always_comb begin
    w_dx_c = r_dx;
    w_lx   = w_l + r_dx;
    if (w_lx[SW-1]) begin
      w_dx_c = -w_l;
    end
    w_rx = w_r + w_dx_c;
    if (w_rx > XMAX_S) begin
      w_dx_c = XMAX_S - w_r;
    end
  end

  plat_clamp #(
    .W(W)
  ) u_plat_clamp (
    .i_l    (w_l),
    .i_r    (w_r),
    .i_b    (w_b),
    .i_dx   (r_dx),
    .i_dy   (r_dy),
    .i_left (w_sel_left),
    .i_right(w_sel_right),
    .i_top  (w_sel_top),
    .o_dx   (w_dx_p),
    .o_dy   (w_dy_p),
    .o_hit_v(w_hit_p),
    .o_touch(w_touch_p)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_pos_x    <= spawn_X;
      r_pos_y    <= spawn_Y;
      r_vy       <= '0;
      r_vy_n     <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_hit_v    <= 1'b0;
      r_touch    <= 1'b0;
      r_grounded <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (frame_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (frame_tick) begin
            r_dx    <= SW'(req_dX);
            r_dy    <= SW'(req_dY) + w_vy_n;
            r_vy_n  <= w_vy_n;
            r_idx   <= '0;
            r_hit_v <= 1'b0;
            r_touch <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_dx    <= w_dx_p;
          r_dy    <= w_dy_p;
          r_hit_v <= r_hit_v | w_hit_p;
          r_touch <= r_touch | w_touch_p;
          if (r_idx == IW'(NUM_PLAT - 1)) begin
            r_idx   <= '0;
            r_state <= ST_CLAMP;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_CLAMP: begin
          r_dx    <= w_dx_c;
          r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_pos_x    <= r_pos_x + r_dx[W-1:0];
          r_pos_y    <= r_pos_y + r_dy[W-1:0];
          r_grounded <= w_gnd;
          r_vy       <= w_gnd ? '0 : r_vy_n;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pos_X    = r_pos_x;
  assign pos_Y    = r_pos_y;
  assign grounded = r_grounded;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overrun  = r_overrun;

endmodule
